// File: rtl/div_unit_pkg.sv
// Shared types for the RV32M iterative divider: op codes, FSM state encoding
// and small op-decode helpers.
package div_unit_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  function automatic logic is_quo_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_DIVU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Turns an unsigned magnitude quotient/remainder into the final RV32M result:
// sign correction plus the divide-by-zero and signed-overflow overrides.
module div_sign_fix
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] quo_raw_i,
  input  logic [XLEN-1:0] rem_raw_i,
  input  logic            sign_a_i,
  input  logic            sign_b_i,
  input  logic [1:0]      op_i,
  input  logic            b_zero_i,
  input  logic            ovf_i,
  output logic [XLEN-1:0] result_o
);

  logic            signed_op;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    signed_op = is_signed_op(op_i);
    quo_fix   = quo_raw_i;
    rem_fix   = rem_raw_i;

    if (signed_op && (sign_a_i != sign_b_i)) begin
      quo_fix = -quo_raw_i;
    end
    if (signed_op && sign_a_i) begin
      rem_fix = -rem_raw_i;
    end

    // Raw remainder is already |a| on divide-by-zero, so it sign-fixes back to a.
    if (b_zero_i) begin
      quo_fix = '1;
    end
    if (ovf_i) begin
      quo_fix = {1'b1, {(XLEN-1){1'b0}}};
      rem_fix = '0;
    end

    result_o = is_rem_op(op_i) ? rem_fix : quo_fix;
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready on
// both sides. Optional macro DIV_EARLY_OUT_EN skips the iteration for trivial ops.
//
// state   | meaning
// IDLE    | waiting for an op, in_ready high
// CALC    | one quotient bit per cycle, XLEN cycles
// FIX     | sign correction and special cases, result registered
// DONE    | out_valid high, result held until out_ready
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      div_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            b_zero_q, b_zero_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_signed;
  logic            in_sign_a;
  logic            in_sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            in_b_zero;
  logic            in_ovf;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;

  logic [XLEN-1:0] fx_quo;
  logic [XLEN-1:0] fx_rem;
  logic            fx_sign_a;
  logic            fx_sign_b;
  logic [1:0]      fx_op;
  logic            fx_b_zero;
  logic            fx_ovf;
  logic [XLEN-1:0] fx_result;

  always_comb begin
    in_signed = is_signed_op(div_sel);
    in_sign_a = in_signed & a[XLEN-1];
    in_sign_b = in_signed & b[XLEN-1];
    abs_a     = in_sign_a ? -a : a;
    abs_b     = in_sign_b ? -b : b;
    in_b_zero = (b == '0);
    in_ovf    = in_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  end

  // rem_q < divisor always holds, so the XLEN+1 bit trial never overflows.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    trial  = rem_sh - {1'b0, dvs_q};
  end

`ifdef DIV_EARLY_OUT_EN
  logic idle;
  logic early_hit;

  // In IDLE the fixer sees the incoming operands so an early-out result is
  // available on the accepting edge; otherwise it sees the latched iteration.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    early_hit = in_b_zero || in_ovf || (abs_a < abs_b);
    fx_quo    = idle ? (in_b_zero ? '1 : '0) : quo_q;
    fx_rem    = idle ? abs_a : rem_q;
    fx_sign_a = idle ? in_sign_a : sign_a_q;
    fx_sign_b = idle ? in_sign_b : sign_b_q;
    fx_op     = idle ? div_sel : op_q;
    fx_b_zero = idle ? in_b_zero : b_zero_q;
    fx_ovf    = idle ? in_ovf : ovf_q;
  end
`else
  always_comb begin
    fx_quo    = quo_q;
    fx_rem    = rem_q;
    fx_sign_a = sign_a_q;
    fx_sign_b = sign_b_q;
    fx_op     = op_q;
    fx_b_zero = b_zero_q;
    fx_ovf    = ovf_q;
  end
`endif

  div_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .quo_raw_i (fx_quo),
    .rem_raw_i (fx_rem),
    .sign_a_i  (fx_sign_a),
    .sign_b_i  (fx_sign_b),
    .op_i      (fx_op),
    .b_zero_i  (fx_b_zero),
    .ovf_i     (fx_ovf),
    .result_o  (fx_result)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    ovf_d    = ovf_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = div_sel;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          b_zero_d = in_b_zero;
          ovf_d    = in_ovf;
          quo_d    = abs_a;
          dvs_d    = abs_b;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (early_hit) begin
            result_d = fx_result;
            state_d  = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fx_result;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      ovf_q    <= ovf_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit; expected values are hand-computed.
// Latency expectation for divide-by-zero follows DIV_EARLY_OUT_EN.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int LAT_MAX = 100;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_BZ = 1;
`else
  localparam int LAT_BZ = 34;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [1:0]      div_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_unit #(
    .XLEN(XLEN),
    .CNT_W(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .div_sel   (div_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the result, optionally stall the consumer for
  // `hold` cycles in DONE, then retire it. exp_lat < 0 skips the latency check.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < LAT_MAX) begin
      tick();
      guard++;
    end
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    div_sel  = op;
    tick();
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0000_0001;
    div_sel  = DIV_OP_DIVU;
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      tick();
      lat++;
    end
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, result, exp);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 32'd50;
      b        = 32'd5;
      tick();
      chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      chk({tag, "_hold_result"}, result, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_retire_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_retire_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    div_sel   = DIV_OP_DIV;
    repeat (3) tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
    run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, -1, 0);
    run_op("div_m7_2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1, 0);
    run_op("rem_m7_2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1, 0);
    run_op("div_7_m2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, -1, 0);
    run_op("rem_7_m2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, -1, 0);
    run_op("remu_big", DIV_OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, -1, 0);
    run_op("div_5_0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_BZ, 0);
    run_op("remu_5_0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, LAT_BZ, 0);
    run_op("rem_m5_0", DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, -1, 0);
    run_op("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, 0);
    run_op("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1, 0);
    run_op("divu_lt", DIV_OP_DIVU, 32'd3, 32'd9, 32'd0, -1, 0);
    run_op("divu_1000_3", DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 34, 5);

    in_valid = 1'b1;
    a        = 32'd1000;
    b        = 32'd3;
    div_sel  = DIV_OP_DIVU;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("flush_pre_busy", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_result", result, 32'd0);
    run_op("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
